// File: rtl/prog_loader.sv
// Program-memory writer: parses a count/word/checksum byte stream into 18-bit
// instruction words, writes them from address 0 and holds the core while loading.
module prog_loader #(
    parameter int DEPTH  = 26,
    parameter int WORD_W = 18,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [0:7]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [0:ADDR_W-1] mem_wa,
    output logic [0:WORD_W-1] mem_wd,
    output logic              core_hold,
    output logic              done,
    output logic              error
);
    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          n_q, xor_q;
    logic [ADDR_W-1:0]   w_q, wa_q;
    logic [0:1]          b0_q;
    logic [0:7]          b1_q;
    logic [0:WORD_W-1]   wd_q;
    logic                acc, can_start, last_word;

    assign in_ready  = state_q inside {S_COUNT, S_B0, S_B1, S_B2, S_CSUM};
    assign core_hold = state_q inside {S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CSUM};
    assign mem_we    = (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign mem_wa    = wa_q;
    assign mem_wd    = wd_q;

    assign acc       = in_valid && in_ready;
    assign can_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
    assign last_word = (w_q + ADDR_W'(1)) == ADDR_W'(n_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR:
                if (start) state_d = S_COUNT;
            S_COUNT:
                if (acc) state_d = (in_data == 8'd0 || in_data > 8'(DEPTH)) ? S_ERR : S_B0;
            S_B0:
                if (acc) state_d = (|in_data[0:5]) ? S_ERR : S_B1;
            S_B1:
                if (acc) state_d = S_B2;
            S_B2:
                if (acc) state_d = S_WRITE;
            S_WRITE:
                state_d = last_word ? S_CSUM : S_B0;
            S_CSUM:
                if (acc) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            default:
                state_d = S_IDLE;
        endcase
    end

    // Datapath; the write address/data are captured with B2 so they stay stable
    // after the strobe while w moves on to the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= '0;
            xor_q <= '0;
            w_q   <= '0;
            wa_q  <= '0;
            wd_q  <= '0;
            b0_q  <= '0;
            b1_q  <= '0;
        end else begin
            if (can_start) xor_q <= '0;
            case (state_q)
                S_COUNT: if (acc) begin
                    n_q   <= in_data;
                    w_q   <= '0;
                    xor_q <= xor_q ^ in_data;
                end
                S_B0: if (acc) begin
                    b0_q  <= in_data[6:7];
                    xor_q <= xor_q ^ in_data;
                end
                S_B1: if (acc) begin
                    b1_q  <= in_data;
                    xor_q <= xor_q ^ in_data;
                end
                S_B2: if (acc) begin
                    wa_q  <= w_q;
                    wd_q  <= {b0_q, b1_q, in_data};
                    xor_q <= xor_q ^ in_data;
                end
                S_WRITE: w_q <= w_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are sent
// and popped when mem_we fires; a shadow RAM mirrors what the program memory holds.
module tb_prog_loader;
    logic        clk = 0, reset = 1, start = 0, in_valid = 0;
    logic [0:7]  in_data = '0;
    logic        in_ready, mem_we, core_hold, done, error;
    logic [0:7]  mem_wa;
    logic [0:17] mem_wd;

    prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0, cyc = 0, last_cyc = 0;
    bit          full_rate = 0, have_last = 0;
    logic [25:0] sb[$];
    logic [17:0] ram[0:255];
    logic [17:0] wimg[0:31];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) chk("spurious_we", 1, 0);
            else begin
                logic [25:0] e;
                e = sb.pop_front();
                chk("we_addr", mem_wa, e[25:18]);
                chk("we_data", mem_wd, e[17:0]);
            end
            if (full_rate && have_last) chk("we_spacing", cyc - last_cyc, 4);
            last_cyc  = cyc;
            have_last = 1;
            ram[mem_wa] = mem_wd;
        end
    end

    function automatic logic [7:0] word_byte(input int i, input int k);
        if (k == 0)      return {6'b0, wimg[i][17:16]};
        else if (k == 1) return wimg[i][15:8];
        else             return wimg[i][7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("rdy_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_rdy", in_ready, 1);
        chk("start_hold", core_hold, 1);
        chk("start_clr", {done, error}, 0);
    endtask

    task automatic load(input int n, input int gap_max, input bit flip, input int start_at,
                        input bit exp_done);
        logic [7:0] cs, b;
        full_rate = (gap_max == 0 && start_at < 0);
        have_last = 0;
        pulse_start();
        cs = n[7:0];
        send_byte(n[7:0], 0);
        for (int i = 0; i < n; i++) begin
            if (i == start_at) begin
                start = 1;
                @(negedge clk);
                start = 0;
            end
            for (int k = 0; k < 3; k++) begin
                b = word_byte(i, k);
                cs ^= b;
                if (k == 2) sb.push_back({i[7:0], wimg[i]});
                send_byte(b, gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0);
            end
        end
        send_byte(flip ? (cs ^ 8'h80) : cs, gap_max > 0 ? gap_max : 0);
        chk("done", done, exp_done);
        chk("error", error, !exp_done);
        chk("hold_fall", core_hold, 0);
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic bad_frame(input string tag);
        chk(tag, error, 1);
        chk("bad_done", done, 0);
        chk("bad_hold", core_hold, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {in_ready, mem_we, core_hold, done, error}, 0);
        chk("rst_wa", mem_wa, 0);
        chk("rst_wd", mem_wd, 0);
        reset = 0;
        @(negedge clk);
        chk("idle_ign_valid", in_ready, 0);

        // two words at full rate
        wimg[0] = 18'h3FFFF;
        wimg[1] = 18'h01234;
        load(2, 0, 0, -1, 1);
        chk("mem0", ram[0], 18'h3FFFF);
        chk("mem1", ram[1], 18'h01234);
        chk("wa_hold", mem_wa, 1);
        chk("wd_hold", mem_wd, 18'h01234);

        // same image with random gaps
        ram[0] = '0;
        ram[1] = '0;
        load(2, 3, 0, -1, 1);
        chk("gap_mem0", ram[0], 18'h3FFFF);
        chk("gap_mem1", ram[1], 18'h01234);

        // framing errors
        pulse_start();
        send_byte(8'h00, 0);
        bad_frame("cnt0_err");
        pulse_start();
        send_byte(8'h1B, 0);
        bad_frame("cnt27_err");
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        bad_frame("b0_err");

        // checksum mismatch on a one-word image
        wimg[0] = 18'h12345;
        ram[0]  = '0;
        load(1, 0, 1, -1, 0);
        chk("csum_mem0", ram[0], 18'h12345);

        // reset during the WRITE of word 1
        wimg[0] = 18'h00111;
        wimg[1] = 18'h00222;
        wimg[2] = 18'h00333;
        full_rate = 0;
        pulse_start();
        send_byte(8'h03, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) begin
                if (k == 2) sb.push_back({i[7:0], wimg[i]});
                send_byte(word_byte(i, k), 0);
            end
        chk("mid_we", mem_we, 1);
        reset = 1;
        @(negedge clk);
        chk("mr_outs", {in_ready, mem_we, core_hold, done, error}, 0);
        chk("mr_wa", mem_wa, 0);
        chk("mr_wd", mem_wd, 0);
        chk("mr_sb", sb.size(), 0);
        reset = 0;
        load(3, 0, 0, -1, 1);
        chk("mr_mem2", ram[2], 18'h00333);

        // full depth with an ignored start mid-load
        for (int i = 0; i < 26; i++) wimg[i] = 18'(i);
        load(26, 0, 0, 10, 1);
        chk("mem25", ram[25], 18'h00019);
        chk("fd_wa", mem_wa, 25);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
